wb_bram_ctrl: RTL and testbench
===============================

# wb_bram_ctrl

Wishbone-classic slave that acts as the initiator on the single-port, byte-writable BRAM port (CLK/EN0/WE0/A0/Di0/Do0). It sits between the user-project Wishbone bus and the BRAM instance. It decodes its address window and inserts a programmable wait. It then drives exactly one BRAM access per bus cycle, captures the registered read data, and returns a single-cycle acknowledge.

## Interface
Parameters:
- DELAY, 10, wait cycles inserted between request acceptance and the BRAM access (0 allowed)
- ADDR_HI, 8'h38, value of wbs_adr_i[31:24] that selects this slave
- N, 20, BRAM word-address bits

Ports:
- CLK  input  1  single clock; all state on posedge
- RSTn  input  1  asynchronous active-low reset
- wbs_cyc_i  input  1  bus cycle
- wbs_stb_i  input  1  strobe
- wbs_we_i  input  1  1 = write
- wbs_sel_i  input  4  byte lanes
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge, one cycle per transfer
- wbs_dat_o  output  32  read data
- EN0  output  1  BRAM enable
- WE0  output  4  BRAM byte write enables
- A0  output  32  BRAM word address
- Di0  output  32  BRAM write data
- Do0  input  32  BRAM read data; registered, valid the cycle after EN0 is high, 0 when EN0 is low

## Operation
- Hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == ADDR_HI). Non-hits are ignored: no ack and no BRAM activity.
- FSM states: IDLE, WAIT, ACCESS, DATA, ACK.
- IDLE:
  - On a hit, latch we, sel, dat_i, and word address {(32-N)'b0, wbs_adr_i[N+1:2]}.
  - Load the counter with DELAY.
  - Go to WAIT, or to ACCESS if DELAY == 0.
- WAIT:
  - Counter decrements each cycle; go to ACCESS when it reaches 1.
  - If wbs_cyc_i drops, return to IDLE. No access and no ack.
- ACCESS (one cycle):
  - EN0 = 1, A0 = latched address, Di0 = latched data.
  - WE0 = latched sel if write, else 4'b0.
  - Always go to DATA.
- DATA (one cycle):
  - EN0 = 0.
  - On a read, register wbs_dat_o <= Do0. On a write, wbs_dat_o holds its value.
  - If wbs_cyc_i is high, go to ACK with wbs_ack_o <= 1. Otherwise go to IDLE with no ack; a write has already committed.
- ACK (one cycle):
  - wbs_ack_o = 1.
  - Go to IDLE; ack clears on that edge.
  - A hit is not re-accepted in this state.
- Outside ACCESS, EN0, WE0, A0 and Di0 are all 0.
- The counter is sized $clog2(DELAY+1), minimum 1 bit. No arithmetic wrap is possible.
- The ADDR_HI compare is exact. Address bits [1:0] and bits above N+1 inside the window are ignored, so BRAM addresses alias.

## Timing
- Reset (RSTn low, asynchronous):
  - state = IDLE, counter = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, EN0 = 0, WE0 = 0, A0 = 0, Di0 = 0.
- Reset asserted mid-transaction aborts immediately. A write only commits if the ACCESS edge occurred before reset.
- Let the hit be sampled at edge E0:
  - EN0 is high during cycle E0+DELAY+1.
  - Do0 is valid during cycle E0+DELAY+2 and is captured at its end.
  - wbs_ack_o is high for exactly cycle E0+DELAY+3.
  - Latency is the same for reads and writes.
- Back-to-back: the next hit can be sampled at the edge that ends the ACK cycle's successor, i.e. IDLE must be reached first. Minimum transfer period is DELAY+4 cycles.
- wbs_dat_o is stable from the ack cycle until the next read's DATA cycle.
- Bus inputs are sampled only in IDLE. Changes to wbs_adr_i, wbs_dat_i, wbs_sel_i or wbs_we_i after acceptance have no effect.

## Test plan
- Reset mid-WAIT: RSTn low -> all outputs 0 asynchronously; after release, EN0 stays 0 and a subsequent request completes normally.
- Write then read, DELAY=10:
  - Write 0xDEADBEEF to 0x3800_0010, sel=4'hF -> EN0=1, WE0=F, A0=4 exactly 11 cycles after acceptance; ack 13 cycles after acceptance.
  - Read of the same address -> wbs_dat_o=0xDEADBEEF with ack at the same latency.
- Byte lanes: write 0x11223344 with sel=4'b0101 over 0xFFFFFFFF, then read -> 0xFF22FF44.
- Miss: request to 0x3000_0000 -> no ack and EN0 never asserts within 50 cycles.
- Abort: drop wbs_cyc_i at cycle 5 of WAIT -> EN0 never asserts, no ack, next request serviced normally.
- DELAY=0 with back-to-back reads of words 0 and 1 -> each ack 3 cycles after acceptance; exactly one EN0 pulse per transfer.

Source files
------------

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone-classic slave that performs one programmable-delay,
// byte-writable access on a registered single-port BRAM per bus cycle.
module wb_bram_ctrl #(
   parameter int         DELAY   = 10,
   parameter logic [7:0] ADDR_HI = 8'h38,
   parameter int         N       = 20
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        EN0,
   output logic [3:0]  WE0,
   output logic [31:0] A0,
   output logic [31:0] Di0,
   input  logic [31:0] Do0
);
   localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   typedef enum logic [2:0] {IDLE, WAIT, ACCESS, DATA, ACK} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_r;
   logic [3:0]    sel_r;
   logic [31:0]   dat_r;
   logic [31:0]   adr_r;
   logic          hit;
   logic [31:0]   word_adr;
   assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == ADDR_HI);
   assign word_adr = {{(32-N){1'b0}}, wbs_adr_i[N+1:2]};
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         cnt       <= '0;
         we_r      <= 1'b0;
         sel_r     <= 4'b0;
         dat_r     <= 32'b0;
         adr_r     <= 32'b0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= 32'b0;
         EN0       <= 1'b0;
         WE0       <= 4'b0;
         A0        <= 32'b0;
         Di0       <= 32'b0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               we_r  <= wbs_we_i;
               sel_r <= wbs_sel_i;
               dat_r <= wbs_dat_i;
               adr_r <= word_adr;
               cnt   <= CW'(DELAY);
               // zero delay launches the access straight from the bus inputs
               if (DELAY == 0) begin
                  state <= ACCESS;
                  EN0   <= 1'b1;
                  WE0   <= wbs_we_i ? wbs_sel_i : 4'b0;
                  A0    <= word_adr;
                  Di0   <= wbs_dat_i;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (!wbs_cyc_i) begin
               state <= IDLE;
            end else begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= ACCESS;
                  EN0   <= 1'b1;
                  WE0   <= we_r ? sel_r : 4'b0;
                  A0    <= adr_r;
                  Di0   <= dat_r;
               end
            end
            ACCESS: begin
               state <= DATA;
               EN0   <= 1'b0;
               WE0   <= 4'b0;
               A0    <= 32'b0;
               Di0   <= 32'b0;
            end
            DATA: begin
               if (!we_r) wbs_dat_o <= Do0;
               // an abandoned write has already committed; only the ack is dropped
               if (wbs_cyc_i) begin
                  state     <= ACK;
                  wbs_ack_o <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            ACK: begin
               state     <= IDLE;
               wbs_ack_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: directed checks of wb_bram_ctrl at DELAY=10 (window 0x38)
// and DELAY=0 (window 0x39), each backed by a registered byte-writable RAM model.
module tb_wb_bram_ctrl;
   logic        CLK, RSTn;
   logic        cyc, stb, we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i, dat_i;
   logic        ack0, en0, ack1, en1;
   logic [3:0]  we0, we1;
   logic [31:0] dato0, a0, di0, do0, dato1, a1, di1, do1;
   logic [31:0] mem0 [0:63];
   logic [31:0] mem1 [0:63];
   int checks = 0;
   int errors = 0;
   wb_bram_ctrl #(.DELAY(10), .ADDR_HI(8'h38), .N(20)) u0 (
      .CLK(CLK), .RSTn(RSTn), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i),
      .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack0),
      .wbs_dat_o(dato0), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0));
   wb_bram_ctrl #(.DELAY(0), .ADDR_HI(8'h39), .N(20)) u1 (
      .CLK(CLK), .RSTn(RSTn), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i),
      .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack1),
      .wbs_dat_o(dato1), .EN0(en1), .WE0(we1), .A0(a1), .Di0(di1), .Do0(do1));
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   // RAM models: read data registered, zero when not enabled
   always_ff @(posedge CLK) begin
      if (en0) begin
         for (int b = 0; b < 4; b++) if (we0[b]) mem0[a0[5:0]][8*b +: 8] <= di0[8*b +: 8];
         do0 <= mem0[a0[5:0]];
      end else do0 <= 32'b0;
      if (en1) begin
         for (int b = 0; b < 4; b++) if (we1[b]) mem1[a1[5:0]][8*b +: 8] <= di1[8*b +: 8];
         do1 <= mem1[a1[5:0]];
      end else do1 <= 32'b0;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic quiet(input int n, output int en_n, output int ack_n);
      en_n = 0;
      ack_n = 0;
      repeat (n) begin
         @(negedge CLK);
         en_n  += int'(en0) + int'(en1);
         ack_n += int'(ack0) + int'(ack1);
      end
   endtask
   task automatic xfer(input int u, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat,
                       output int en_at, output int ack_at, output int en_n,
                       output logic [3:0] we_s, output logic [31:0] a_s,
                       output logic [31:0] di_s, output logic [31:0] rd);
      en_at = 0; ack_at = 0; en_n = 0; we_s = 0; a_s = 0; di_s = 0; rd = 0;
      @(negedge CLK);
      cyc = 1; stb = 1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
      for (int k = 1; k <= 40 && ack_at == 0; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            adr_i = 32'h0; dat_i = 32'h0; sel_i = 4'h0; we_i = ~we;
         end
         if (u ? en1 : en0) begin
            en_n++;
            if (en_at == 0) begin
               en_at = k;
               we_s  = u ? we1 : we0;
               a_s   = u ? a1 : a0;
               di_s  = u ? di1 : di0;
            end
         end
         if (u ? ack1 : ack0) begin
            ack_at = k;
            rd = u ? dato1 : dato0;
         end
      end
      cyc = 0; stb = 0;
   endtask
   initial begin
      int en_at, ack_at, en_n, q_en, q_ack;
      logic [3:0] we_s;
      logic [31:0] a_s, di_s, rd;
      RSTn = 0; cyc = 0; stb = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
      repeat (3) @(negedge CLK);
      chk("rst_ack", {31'b0, ack0}, 0);
      chk("rst_en", {31'b0, en0 | en1}, 0);
      chk("rst_dat", dato0 | dato1, 0);
      chk("rst_a_di_we", a0 | di0 | {28'b0, we0}, 0);
      RSTn = 1;
      xfer(0, 1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("wr_en_lat", en_at, 11);
      chk("wr_ack_lat", ack_at, 13);
      chk("wr_en_pulses", en_n, 1);
      chk("wr_we", {28'b0, we_s}, 32'hF);
      chk("wr_a", a_s, 4);
      chk("wr_di", di_s, 32'hDEAD_BEEF);
      xfer(0, 0, 4'hF, 32'h3800_0010, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("rd_data", rd, 32'hDEAD_BEEF);
      chk("rd_en_lat", en_at, 11);
      chk("rd_ack_lat", ack_at, 13);
      chk("rd_we", {28'b0, we_s}, 0);
      @(negedge CLK);
      cyc = 1; stb = 1; we_i = 1; sel_i = 4'hF; adr_i = 32'h3800_0010; dat_i = 32'hA5A5_A5A5;
      repeat (5) @(negedge CLK);
      RSTn = 0;
      #1;
      chk("mid_rst_dat", dato0, 0);
      chk("mid_rst_ack_en", {30'b0, ack0, en0}, 0);
      cyc = 0; stb = 0;
      @(negedge CLK);
      RSTn = 1;
      quiet(20, q_en, q_ack);
      chk("post_rst_en", q_en, 0);
      xfer(0, 0, 4'hF, 32'h3800_0010, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("post_rst_rd", rd, 32'hDEAD_BEEF);
      chk("post_rst_ack_lat", ack_at, 13);
      xfer(0, 1, 4'hF, 32'h3800_0020, 32'hFFFF_FFFF, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      xfer(0, 1, 4'b0101, 32'h3800_0020, 32'h1122_3344, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("lane_we", {28'b0, we_s}, 32'h5);
      xfer(0, 0, 4'hF, 32'h3800_0020, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("lane_rd", rd, 32'hFF22_FF44);
      @(negedge CLK);
      cyc = 1; stb = 1; we_i = 1; sel_i = 4'hF; adr_i = 32'h3000_0000; dat_i = 32'h1234_5678;
      quiet(50, q_en, q_ack);
      cyc = 0; stb = 0;
      chk("miss_en", q_en, 0);
      chk("miss_ack", q_ack, 0);
      @(negedge CLK);
      cyc = 1; stb = 1; we_i = 1; sel_i = 4'hF; adr_i = 32'h3800_0010; dat_i = 32'h5555_5555;
      repeat (5) @(negedge CLK);
      cyc = 0; stb = 0;
      quiet(30, q_en, q_ack);
      chk("abort_en", q_en, 0);
      chk("abort_ack", q_ack, 0);
      xfer(0, 0, 4'hF, 32'h3800_0010, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("abort_rd", rd, 32'hDEAD_BEEF);
      chk("abort_ack_lat", ack_at, 13);
      xfer(1, 1, 4'hF, 32'h3900_0000, 32'h0000_AAAA, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("d0_wr_en_lat", en_at, 1);
      chk("d0_wr_ack_lat", ack_at, 3);
      xfer(1, 1, 4'hF, 32'h3900_0004, 32'h0000_BBBB, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("d0_wr1_a", a_s, 1);
      xfer(1, 0, 4'hF, 32'h3900_0000, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("d0_rd0", rd, 32'h0000_AAAA);
      chk("d0_rd0_ack_lat", ack_at, 3);
      chk("d0_rd0_pulses", en_n, 1);
      xfer(1, 0, 4'hF, 32'h3900_0004, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("d0_rd1", rd, 32'h0000_BBBB);
      chk("d0_rd1_ack_lat", ack_at, 3);
      chk("d0_rd1_pulses", en_n, 1);
      xfer(1, 0, 4'hF, 32'h3940_0007, 32'h0, en_at, ack_at, en_n, we_s, a_s, di_s, rd);
      chk("alias_a", a_s, 1);
      chk("alias_rd", rd, 32'h0000_BBBB);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
